wbc_vic_pri: RTL and testbench
==============================

Name: wbc_vic_pri

Overview:
Parametrised successor of the vectored interrupt controller for the Wishbone-based PDP-11 core.
- Arbitrates N request lines using a per-channel 3-bit priority and a per-channel mask.
- Supports level-sensitive and rising-edge-latched channels, selected per channel.
- Suppresses any request whose priority does not exceed the CPU's current priority.
- Delivers the winning 16-bit vector to the CPU over the stb/ack vector-fetch handshake and pulses the matching iack to the device.

Parameters:
N, 4, number of interrupt channels (1..32)
EDGE, {N{1'b0}}, per-channel mode bit: 1 = rising-edge latched, 0 = level
PW, 3, priority field width per channel

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  asynchronous reset, active-high
wb_irq_o  out  1  vectored interrupt request to CPU
wb_dat_o  out  16  vector to CPU
wb_stb_i  in  1  CPU vector-fetch strobe
wb_ack_o  out  1  vector-valid acknowledge
cpu_pri  in  PW  current CPU priority (PSW[7:5])
ivec  in  N*16  vector array, channel i at [16i+15:16i]
ipri  in  N*PW  priority array, channel i at [PW*i+PW-1:PW*i]
imask  in  N  1 = channel masked
ireq  in  N  device request lines
iack  out  N  one-cycle acknowledge to the granted device

Behaviour:
Reset (asynchronous, active-high): wb_irq_o=0, wb_ack_o=0, wb_dat_o=0, iack=0, pend=0, ireq_d=0, state=IDLE, nvec=0.

Pending logic:
- Edge channels: pend[i] sets when ireq[i] & ~ireq_d[i] (ireq_d is the registered copy of ireq).
- Edge channels: pend[i] clears in the cycle iack[i] is asserted. A new edge in that same cycle wins, and pend stays 1.
- Level channels: pend[i] = ireq[i]. No latching is performed.

Eligibility and arbitration:
- Eligible: elig[i] = pend[i] & ~imask[i] & (ipri[i] > cpu_pri), compared unsigned.
- Winner: the eligible channel with the highest ipri. Ties go to the lowest index.
- The winner logic is combinational and is registered into nvec by the FSM.

FSM, states IDLE, REQ, ACK:
- IDLE:
  - If any elig: nvec <= winner, wb_irq_o <= 1, go to REQ.
  - Latency: a level request is seen on wb_irq_o 1 cycle after it is asserted; an edge request after 2 cycles.
- REQ, with wb_stb_i=0:
  - Re-arbitrate every cycle and update nvec, so a higher-priority arrival preempts.
  - If no elig remains: wb_irq_o <= 0, go to IDLE. A request withdrawn before the fetch is dropped silently.
- REQ, with wb_stb_i=1:
  - Freeze nvec.
  - Next cycle: wb_dat_o <= ivec[nvec], wb_ack_o <= 1, iack[nvec] <= 1, wb_irq_o <= 0. Go to ACK.
  - The ack is granted even if the channel deasserted in the stb cycle, because the vector was committed when nvec froze.
- ACK:
  - wb_ack_o and iack are high for exactly one cycle, then drop.
  - Remain in ACK until wb_stb_i=0, then go to IDLE. Re-arbitration resumes from IDLE, with a minimum 1-cycle gap between consecutive ack pulses.
- wb_stb_i asserted in IDLE: no ack is generated. The CPU bus timeout handles this case.

Output and width rules:
- wb_dat_o holds its last vector until the next fetch.
- iack is one-hot or zero at all times.
- cpu_pri and imask changes in REQ take effect at the next re-arbitration. A masked or outprioritised winner causes irq to drop if no other channel is eligible.
- Reset asserted mid-handshake returns everything to reset values immediately. All latched edges are lost.

Decomposition:
- Package wbc_vic_pkg:
  - VEC_W=16 and PW default.
  - State enum {IDLE, REQ, ACK}.
  - Function returning the field of channel i from a packed array.
- Sub-module wbc_vic_arb (combinational):
  - Inputs: elig, ipri.
  - Outputs: any, win index (clog2(N) bits).
  - Implementation: priority compare tree with lowest-index tie-break.

Test Plan:
- N=4, level. ireq=0100, ipri[2]=5, cpu_pri=3 -> wb_irq_o high 1 cycle later. stb -> ack+iack[2] next cycle, wb_dat_o=ivec[2]=0o000100.
- Two channels, ipri[1]=6 and ipri[3]=6, cpu_pri=0 -> channel 1 granted. Change ipri[3]=7 before stb -> channel 3 granted, vector ivec[3].
- cpu_pri=5, sole request at ipri=5 -> wb_irq_o stays 0. Lower cpu_pri to 4 -> irq rises next cycle.
- EDGE[0]=1. ireq[0] pulses high for 1 cycle -> pend holds, irq raised and stays until fetch. Second edge in the iack cycle -> irq re-raised after stb drops.
- imask[2] set while in REQ with only channel 2 eligible -> wb_irq_o drops next cycle. No ack on a later stb.
- Reset asserted in the ACK cycle -> wb_ack_o, iack, wb_irq_o and wb_dat_o all 0 immediately (asynchronous). Edge pend cleared.

Source files
------------

// File: rtl/wbc_vic_pri_pkg.sv
// -----------------------------------------------------------------------------
// wbc_vic_pkg
// Shared definitions for the vectored interrupt controller (wbc_vic_pri).
//   VEC_W       : width of one interrupt vector
//   PW_DEFAULT  : default width of one channel priority field
//   MAX_N       : largest supported channel count
//   MAX_BITS    : width of the widest packed per-channel array
//   state_t     : vector-fetch handshake states
//   getField()  : extracts field idx of width w from a packed array
// -----------------------------------------------------------------------------
package wbc_vic_pkg;

    localparam int VEC_W      = 16;
    localparam int PW_DEFAULT = 3;
    localparam int MAX_N      = 32;
    localparam int MAX_BITS   = MAX_N * VEC_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } state_t;

    // Callers zero-extend their packed array to MAX_BITS so one helper
    // serves both the vector array and the priority array.
    function automatic logic [VEC_W-1:0] getField(
        input logic [MAX_BITS-1:0] arr,
        input int                  idx,
        input int                  w
    );
        logic [MAX_BITS-1:0] shifted;
        logic [VEC_W-1:0]    mask;
        shifted = arr >> (idx * w);
        mask    = (w >= VEC_W) ? '1 : ((VEC_W'(1) << w) - VEC_W'(1));
        return shifted[VEC_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/wbc_vic_pri_if.sv
// -----------------------------------------------------------------------------
// wbc_vic_pri_if
// CPU-side vector-fetch bus of the interrupt controller.
//   wb_irq_o : vectored interrupt request to the CPU
//   wb_dat_o : vector returned to the CPU
//   wb_stb_i : CPU vector-fetch strobe
//   wb_ack_o : vector-valid acknowledge
//   cpu_pri  : current CPU priority (PSW[7:5])
// Modports: master = CPU side, slave = controller side.
// -----------------------------------------------------------------------------
interface wbc_vic_pri_if
    import wbc_vic_pkg::*;
#(
    parameter int PW = PW_DEFAULT
);

    logic             wb_irq_o;
    logic [VEC_W-1:0] wb_dat_o;
    logic             wb_stb_i;
    logic             wb_ack_o;
    logic [PW-1:0]    cpu_pri;

    modport master (
        input  wb_irq_o,
        input  wb_dat_o,
        input  wb_ack_o,
        output wb_stb_i,
        output cpu_pri
    );

    modport slave (
        output wb_irq_o,
        output wb_dat_o,
        output wb_ack_o,
        input  wb_stb_i,
        input  cpu_pri
    );

endinterface

// File: rtl/wbc_vic_pri_arb.sv
// -----------------------------------------------------------------------------
// wbc_vic_arb
// Combinational priority arbiter.
//   i_elig : per-channel eligibility
//   i_ipri : packed per-channel priorities, channel i at [PW*i +: PW]
//   o_any  : at least one channel is eligible
//   o_win  : index of the eligible channel with the highest priority;
//            ties resolve to the lowest index
// -----------------------------------------------------------------------------
module wbc_vic_arb
    import wbc_vic_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = PW_DEFAULT,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    i_elig,
    input  logic [N*PW-1:0] i_ipri,
    output logic            o_any,
    output logic [IW-1:0]   o_win
);

    logic [MAX_BITS-1:0] w_ipriExt;
    logic [PW-1:0]       w_pri;
    logic [PW-1:0]       w_bestPri;
    logic                w_found;

    // Channels are scanned upward and only a strictly greater priority
    // replaces the current best, which gives the lowest index on a tie.
    always_comb begin
        w_ipriExt              = '0;
        w_ipriExt[N*PW-1:0]    = i_ipri;
        w_pri                  = '0;
        w_bestPri              = '0;
        w_found                = 1'b0;
        o_win                  = '0;
        for (int i = 0; i < N; i++) begin
            w_pri = PW'(getField(w_ipriExt, i, PW));
            if (i_elig[i] && (!w_found || (w_pri > w_bestPri))) begin
                w_found   = 1'b1;
                w_bestPri = w_pri;
                o_win     = IW'(i);
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/wbc_vic_pri.sv
// -----------------------------------------------------------------------------
// wbc_vic_pri
// Vectored interrupt controller with per-channel priority, mask and
// level/edge mode for the Wishbone PDP-11 core.
//   wb_clk_i : system clock
//   wb_rst_i : asynchronous reset, active-high
//   bus      : CPU vector-fetch bus (irq, dat, stb, ack, cpu_pri)
//   ivec     : vector array, channel i at [16i+15:16i]
//   ipri     : priority array, channel i at [PW*i+PW-1:PW*i]
//   imask    : 1 = channel masked
//   ireq     : device request lines
//   iack     : one-cycle acknowledge to the granted device
// -----------------------------------------------------------------------------
module wbc_vic_pri
    import wbc_vic_pkg::*;
#(
    parameter int          N    = 4,
    parameter logic [N-1:0] EDGE = '0,
    parameter int          PW   = PW_DEFAULT
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    wbc_vic_pri_if.slave       bus,
    input  logic [N*VEC_W-1:0] ivec,
    input  logic [N*PW-1:0]    ipri,
    input  logic [N-1:0]       imask,
    input  logic [N-1:0]       ireq,
    output logic [N-1:0]       iack
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    state_t              r_state;
    state_t              w_stateNext;
    logic [N-1:0]        r_ireqD;
    logic [N-1:0]        r_pend;
    logic [N-1:0]        w_pend;
    logic [N-1:0]        w_elig;
    logic                w_any;
    logic [IW-1:0]       w_win;
    logic [IW-1:0]       r_nvec;
    logic [IW-1:0]       w_nvecNext;
    logic                r_irq;
    logic                w_irqNext;
    logic                r_ack;
    logic                w_ackNext;
    logic [VEC_W-1:0]    r_dat;
    logic [VEC_W-1:0]    w_datNext;
    logic [N-1:0]        r_iack;
    logic [N-1:0]        w_iackNext;
    logic [MAX_BITS-1:0] w_ivecExt;

    // Edge channels latch a rising edge until their iack; a fresh edge in
    // the iack cycle keeps the channel pending. Level channels never latch.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ireqD <= '0;
            r_pend  <= '0;
        end else begin
            r_ireqD <= ireq;
            r_pend  <= EDGE & ((r_pend & ~r_iack) | (ireq & ~r_ireqD));
        end
    end

    always_comb begin
        w_pend = (EDGE & r_pend) | (~EDGE & ireq);
    end

    // A channel competes only when pending, unmasked and strictly above
    // the CPU's current priority.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < N; i++) begin
            w_elig[i] = w_pend[i] & ~imask[i] & (ipri[i*PW +: PW] > bus.cpu_pri);
        end
    end

    wbc_vic_arb #(
        .N  (N),
        .PW (PW)
    ) u_arb (
        .i_elig (w_elig),
        .i_ipri (ipri),
        .o_any  (w_any),
        .o_win  (w_win)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // ACK is held until the CPU releases stb, which guarantees an idle
    // cycle between consecutive acknowledges.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (w_any) w_stateNext = REQ;
            REQ:     if (bus.wb_stb_i) w_stateNext = ACK;
                     else if (!w_any) w_stateNext = IDLE;
            ACK:     if (!bus.wb_stb_i) w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // Once stb is seen in REQ the vector is committed from the frozen
    // nvec, so the ack goes out even if the device has already let go.
    always_comb begin
        w_nvecNext = r_nvec;
        w_irqNext  = r_irq;
        w_ackNext  = 1'b0;
        w_datNext  = r_dat;
        w_iackNext = '0;
        w_ivecExt  = '0;
        w_ivecExt[N*VEC_W-1:0] = ivec;
        case (r_state)
            IDLE: begin
                w_irqNext = w_any;
                if (w_any) w_nvecNext = w_win;
            end
            REQ: begin
                if (bus.wb_stb_i) begin
                    w_datNext          = getField(w_ivecExt, int'(r_nvec), VEC_W);
                    w_ackNext          = 1'b1;
                    w_iackNext[r_nvec] = 1'b1;
                    w_irqNext          = 1'b0;
                end else begin
                    w_irqNext = w_any;
                    if (w_any) w_nvecNext = w_win;
                end
            end
            ACK: begin
                w_irqNext = 1'b0;
            end
            default: begin
                w_irqNext = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_nvec <= '0;
            r_irq  <= 1'b0;
            r_ack  <= 1'b0;
            r_dat  <= '0;
            r_iack <= '0;
        end else begin
            r_nvec <= w_nvecNext;
            r_irq  <= w_irqNext;
            r_ack  <= w_ackNext;
            r_dat  <= w_datNext;
            r_iack <= w_iackNext;
        end
    end

    assign bus.wb_irq_o = r_irq;
    assign bus.wb_ack_o = r_ack;
    assign bus.wb_dat_o = r_dat;
    assign iack         = r_iack;

endmodule

// File: tb/tb_wbc_vic_pri.sv
// -----------------------------------------------------------------------------
// tb_wbc_vic_pri
// Directed scenarios followed by randomized traffic, all compared each cycle
// against a transaction-level model of the interrupt controller.
// -----------------------------------------------------------------------------
module tb_wbc_vic_pri;
    import wbc_vic_pkg::*;

    localparam int           N      = 4;
    localparam int           PW     = 3;
    localparam logic [N-1:0] EDGE_P = 4'b0001;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [N*VEC_W-1:0] ivec;
    logic [N*PW-1:0]    ipri;
    logic [N-1:0]       imask;
    logic [N-1:0]       ireq;
    logic [N-1:0]       iack;

    int checks = 0;
    int errors = 0;

    wbc_vic_pri_if #(.PW(PW)) bus ();

    wbc_vic_pri #(
        .N    (N),
        .EDGE (EDGE_P),
        .PW   (PW)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus),
        .ivec     (ivec),
        .ipri     (ipri),
        .imask    (imask),
        .ireq     (ireq),
        .iack     (iack)
    );

    always #5 clk = ~clk;

    // Model: which channels hold a latched edge, what the CPU was offered,
    // and where the handshake stands (0 waiting, 1 offering, 2 acknowledging).
    bit          mPendE [N];
    bit          mIreqD [N];
    int          mPhase;
    int          mVec;
    int          mIackCh;
    bit          mIrq;
    bit          mAck;
    logic [15:0] mDat;

    function automatic int priOf(int i);
        return int'(ipri[PW*i +: PW]);
    endfunction

    function automatic bit pendingOf(int i);
        return EDGE_P[i] ? mPendE[i] : ireq[i];
    endfunction

    function automatic bit eligibleOf(int i);
        return pendingOf(i) && !imask[i] && (priOf(i) > int'(bus.cpu_pri));
    endfunction

    // Highest priority level first, then lowest channel number.
    function automatic int pickWinner();
        int best;
        best = -1;
        for (int p = 7; p >= 0; p--) begin
            for (int i = 0; i < N; i++) begin
                if (best < 0 && eligibleOf(i) && priOf(i) == p) best = i;
            end
        end
        return best;
    endfunction

    function automatic logic [15:0] vecOf(int i);
        return ivec[16*i +: 16];
    endfunction

    task automatic modelReset();
        for (int i = 0; i < N; i++) begin
            mPendE[i] = 1'b0;
            mIreqD[i] = 1'b0;
        end
        mPhase  = 0;
        mVec    = 0;
        mIackCh = -1;
        mIrq    = 1'b0;
        mAck    = 1'b0;
        mDat    = '0;
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic [N-1:0] expIack;
        expIack = '0;
        if (mIackCh >= 0) expIack[mIackCh] = 1'b1;
        checkVal("irq",  32'(bus.wb_irq_o), 32'(mIrq));
        checkVal("ack",  32'(bus.wb_ack_o), 32'(mAck));
        checkVal("dat",  32'(bus.wb_dat_o), 32'(mDat));
        checkVal("iack", 32'(iack),         32'(expIack));
    endtask

    // Drive one cycle of inputs, advance the model across the clock edge
    // and compare all CPU- and device-side outputs just after it.
    task automatic applyStimulus(input logic [N-1:0] req, input logic [N-1:0] mask,
                                 input logic stb, input logic [PW-1:0] cpri);
        bit          nPend [N];
        int          win;
        int          nPhase, nVec, nIackCh;
        bit          nIrq, nAck;
        logic [15:0] nDat;
        ireq         = req;
        imask        = mask;
        bus.wb_stb_i = stb;
        bus.cpu_pri  = cpri;
        win     = pickWinner();
        nPhase  = mPhase;
        nVec    = mVec;
        nIackCh = -1;
        nAck    = 1'b0;
        nDat    = mDat;
        nIrq    = 1'b0;
        for (int i = 0; i < N; i++) begin
            nPend[i] = EDGE_P[i] && ((ireq[i] && !mIreqD[i]) || (mPendE[i] && mIackCh != i));
        end
        if (mPhase == 0) begin
            if (win >= 0) begin
                nVec = win; nIrq = 1'b1; nPhase = 1;
            end
        end else if (mPhase == 1) begin
            if (stb) begin
                nDat = vecOf(mVec); nAck = 1'b1; nIackCh = mVec; nPhase = 2;
            end else if (win >= 0) begin
                nVec = win; nIrq = 1'b1;
            end else begin
                nPhase = 0;
            end
        end else begin
            if (!stb) nPhase = 0;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            mPendE[i] = nPend[i];
            mIreqD[i] = ireq[i];
        end
        mPhase = nPhase; mVec = nVec; mIackCh = nIackCh;
        mIrq = nIrq; mAck = nAck; mDat = nDat;
        checkOutput();
    endtask

    initial begin
        ivec         = {16'o000140, 16'o000100, 16'o000060, 16'o000004};
        ipri         = '0;
        imask        = '0;
        ireq         = '0;
        bus.wb_stb_i = 1'b0;
        bus.cpu_pri  = '0;
        modelReset();
        #12;
        checkOutput();
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] level channel 2 above cpu priority");
        ipri = {3'd0, 3'd5, 3'd0, 3'd0};
        applyStimulus(4'b0100, 4'b0000, 1'b0, 3'd3);
        checkVal("t1_irq", 32'(bus.wb_irq_o), 32'd1);
        applyStimulus(4'b0100, 4'b0000, 1'b1, 3'd3);
        checkVal("t1_dat", 32'(bus.wb_dat_o), 32'o000100);
        checkVal("t1_iack", 32'(iack), 32'b0100);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 3'd3);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 3'd3);

        $display("[TB] tie then preemption by priority raise");
        ipri = {3'd6, 3'd0, 3'd6, 3'd0};
        applyStimulus(4'b1010, 4'b0000, 1'b0, 3'd0);
        ipri = {3'd7, 3'd0, 3'd6, 3'd0};
        applyStimulus(4'b1010, 4'b0000, 1'b0, 3'd0);
        applyStimulus(4'b1010, 4'b0000, 1'b1, 3'd0);
        checkVal("t2_iack", 32'(iack), 32'b1000);
        checkVal("t2_dat", 32'(bus.wb_dat_o), 32'o000140);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 3'd0);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 3'd0);

        $display("[TB] request equal to cpu priority is suppressed");
        ipri = {3'd0, 3'd5, 3'd0, 3'd0};
        applyStimulus(4'b0100, 4'b0000, 1'b0, 3'd5);
        applyStimulus(4'b0100, 4'b0000, 1'b0, 3'd5);
        checkVal("t3_irq_low", 32'(bus.wb_irq_o), 32'd0);
        applyStimulus(4'b0100, 4'b0000, 1'b0, 3'd4);
        checkVal("t3_irq_high", 32'(bus.wb_irq_o), 32'd1);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 3'd4);
        checkVal("t3_withdrawn", 32'(bus.wb_irq_o), 32'd0);

        $display("[TB] edge channel 0 latch and re-arm");
        ipri = {3'd0, 3'd0, 3'd0, 3'd4};
        applyStimulus(4'b0001, 4'b0000, 1'b0, 3'd0);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 3'd0);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 3'd0);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 3'd0);
        checkVal("t4_irq_hold", 32'(bus.wb_irq_o), 32'd1);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 3'd0);
        checkVal("t4_iack", 32'(iack), 32'b0001);
        applyStimulus(4'b0001, 4'b0000, 1'b1, 3'd0);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 3'd0);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 3'd0);
        checkVal("t4_rearm", 32'(bus.wb_irq_o), 32'd1);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 3'd0);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 3'd0);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 3'd0);

        $display("[TB] mask applied while offering");
        ipri = {3'd0, 3'd5, 3'd0, 3'd0};
        applyStimulus(4'b0100, 4'b0000, 1'b0, 3'd0);
        applyStimulus(4'b0100, 4'b0100, 1'b0, 3'd0);
        checkVal("t5_masked", 32'(bus.wb_irq_o), 32'd0);
        applyStimulus(4'b0100, 4'b0100, 1'b1, 3'd0);
        checkVal("t5_no_ack", 32'(bus.wb_ack_o), 32'd0);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 3'd0);

        $display("[TB] reset during acknowledge");
        ipri = {3'd0, 3'd0, 3'd0, 3'd4};
        applyStimulus(4'b0001, 4'b0000, 1'b0, 3'd0);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 3'd0);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 3'd0);
        ireq = 4'b0001;
        #2;
        rst = 1'b1;
        #1;
        checkVal("t6_ack", 32'(bus.wb_ack_o), 32'd0);
        checkVal("t6_iack", 32'(iack), 32'd0);
        checkVal("t6_irq", 32'(bus.wb_irq_o), 32'd0);
        checkVal("t6_dat", 32'(bus.wb_dat_o), 32'd0);
        modelReset();
        ireq         = '0;
        bus.wb_stb_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(4'b0000, 4'b0000, 1'b0, 3'd0);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 3'd0);
        checkVal("t6_pend_lost", 32'(bus.wb_irq_o), 32'd0);

        $display("[TB] randomized traffic");
        ivec = {$urandom, $urandom};
        ipri = N*PW'($urandom);
        for (int k = 0; k < 600; k++) begin
            logic [N-1:0]  rReq;
            logic [N-1:0]  rMask;
            logic          rStb;
            logic [PW-1:0] rPri;
            if ($urandom_range(0, 7) == 0) ipri = N*PW'($urandom);
            if ($urandom_range(0, 15) == 0) ivec = {$urandom, $urandom};
            rReq  = N'($urandom);
            rMask = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            rStb  = ($urandom_range(0, 2) == 0);
            rPri  = PW'($urandom_range(0, 4));
            applyStimulus(rReq, rMask, rStb, rPri);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
